// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory-access link (master and responder).
//   CMD_WR / CMD_RD : value of the leading command bit of every frame
//   *_DEF           : default address/data widths and memory depth
//   state_e         : master FSM states
package spi_mem_pkg;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    localparam int ADDR_W_DEF    = 6;
    localparam int DATA_W_DEF    = 28;
    localparam int MEM_DEPTH_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD_ADDR,
        ST_TURN,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_mem_master_clk_gen.sv
// SCLK divider: SCLK toggles every HALF_DIV cycles while enabled.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : run the divider
//   restart_i      : synchronous restart (counter cleared, SCLK low)
//   sclk_o         : serial clock, idle low
//   rise_tick_o    : high in the cycle whose closing edge raises SCLK
//   fall_tick_o    : high in the cycle whose closing edge lowers SCLK
module spi_clk_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc = (cnt_q == CNT_W'(HALF_DIV - 1));

    // Counter reloads on every SCLK edge so each half-period is exactly HALF_DIV.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (restart_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (tc) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign rise_tick_o = en_i && !restart_i && tc && !sclk_q;
    assign fall_tick_o = en_i && !restart_i && tc &&  sclk_q;

endmodule

// File: rtl/spi_mem_master.sv
// SPI initiator for single-word reads/writes into the board's shared memory.
// Mode 0, MSB first. Frame: cmd bit, address, (reads: turnaround), data.
//   iCLK, iRSTn     : clock, asynchronous active-low reset
//   iCLR            : synchronous clear (keeps oRDATA), beats iSTART
//   iSTART/iWR/iADDR/iWDATA : request, sampled only while idle
//   oBUSY           : frame or inter-frame CS gap in progress
//   oDONE           : one-cycle completion pulse
//   oRDATA          : last read result, updated with oDONE
//   oERR            : one-cycle pulse for an out-of-range address
//   SCLK/MOSI/MISO/CS : serial link, CS active-low
module spi_mem_master #(
    parameter int HALF_DIV  = 2,
    parameter int TURN_BITS = 1,
    parameter int CS_GAP    = 4,
    parameter int ADDR_W    = spi_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W    = spi_mem_pkg::DATA_W_DEF,
    parameter int MEM_DEPTH = spi_mem_pkg::MEM_DEPTH_DEF
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iCLR,
    input  logic              iSTART,
    input  logic              iWR,
    input  logic [ADDR_W-1:0] iADDR,
    input  logic [DATA_W-1:0] iWDATA,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [DATA_W-1:0] oRDATA,
    output logic              oERR,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS
);

    import spi_mem_pkg::*;

    localparam int FRAME_W  = 1 + ADDR_W + DATA_W;
    localparam int BIT_W    = $clog2(FRAME_W + TURN_BITS + 1);
    localparam int WAIT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

    state_e              state_q;
    logic [FRAME_W-1:0]  tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                wr_q;
    logic [BIT_W-1:0]    bit_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                cs_q, mosi_q, busy_q, done_q, err_q;

    logic shifting, clk_restart, rise_tick, fall_tick;

    assign shifting    = (state_q == ST_CMD_ADDR) || (state_q == ST_TURN) ||
                         (state_q == ST_DATA);
    assign clk_restart = iCLR || !shifting;

    spi_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .clk_i       (iCLK),
        .rst_ni      (iRSTn),
        .en_i        (shifting),
        .restart_i   (clk_restart),
        .sclk_o      (SCLK),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            bit_q   <= '0;
            wait_q  <= '0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (iCLR) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            wait_q  <= '0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        if ({1'b0, iADDR} >= DEPTH_C) begin
                            err_q <= 1'b1;
                        end else begin
                            // Read frames carry zeros after the address, so the
                            // same left shift drives MOSI=0 through turn and data.
                            wr_q    <= iWR;
                            tx_q    <= {(iWR ? CMD_WR : CMD_RD), iADDR,
                                        (iWR ? iWDATA : {DATA_W{1'b0}})};
                            busy_q  <= 1'b1;
                            wait_q  <= '0;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    // CS falls on entry; first SCLK rise follows CS by HALF_DIV
                    // plus one normal low half-period.
                    cs_q   <= 1'b0;
                    mosi_q <= tx_q[FRAME_W-1];
                    wait_q <= wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(HALF_DIV)) begin
                        bit_q   <= '0;
                        state_q <= ST_CMD_ADDR;
                    end
                end
                ST_CMD_ADDR: begin
                    if (fall_tick) begin
                        tx_q   <= tx_q << 1;
                        bit_q  <= bit_q + BIT_W'(1);
                        mosi_q <= tx_q[FRAME_W-2];
                        if (bit_q == BIT_W'(ADDR_W)) begin
                            bit_q <= '0;
                            if (!wr_q && (TURN_BITS > 0)) begin
                                mosi_q  <= 1'b0;
                                state_q <= ST_TURN;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end
                ST_TURN: begin
                    if (fall_tick) begin
                        bit_q  <= bit_q + BIT_W'(1);
                        mosi_q <= 1'b0;
                        if (bit_q == BIT_W'(TURN_BITS - 1)) begin
                            bit_q   <= '0;
                            mosi_q  <= tx_q[FRAME_W-1];
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rise_tick && !wr_q) begin
                        rx_q <= {rx_q[DATA_W-2:0], MISO};
                    end
                    if (fall_tick) begin
                        tx_q   <= tx_q << 1;
                        bit_q  <= bit_q + BIT_W'(1);
                        mosi_q <= tx_q[FRAME_W-2];
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            wait_q  <= '0;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    wait_q <= wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(HALF_DIV - 1)) begin
                        cs_q    <= 1'b1;
                        done_q  <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= rx_q;
                        end
                        wait_q  <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    wait_q <= wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(CS_GAP - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oBUSY  = busy_q;
    assign oDONE  = done_q;
    assign oERR   = err_q;
    assign oRDATA = rdata_q;
    assign MOSI   = mosi_q;
    assign CS     = cs_q;

endmodule

// File: tb/tb_spi_mem_master.sv
module tb_spi_mem_master;

    localparam int CS_GAP = 4;

    logic        iCLK   = 1'b0;
    logic        iRSTn  = 1'b1;
    logic        iCLR   = 1'b0;
    logic        iSTART = 1'b0;
    logic        iWR    = 1'b0;
    logic [5:0]  iADDR  = '0;
    logic [27:0] iWDATA = '0;
    logic        MISO   = 1'b0;
    logic        oBUSY, oDONE, oERR, SCLK, MOSI, CS;
    logic [27:0] oRDATA;

    int checks = 0;
    int errors = 0;

    spi_mem_master #(
        .HALF_DIV (2),
        .TURN_BITS(1),
        .CS_GAP   (CS_GAP),
        .ADDR_W   (6),
        .DATA_W   (28),
        .MEM_DEPTH(48)
    ) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iCLR  (iCLR),
        .iSTART(iSTART),
        .iWR   (iWR),
        .iADDR (iADDR),
        .iWDATA(iWDATA),
        .oBUSY (oBUSY),
        .oDONE (oDONE),
        .oRDATA(oRDATA),
        .oERR  (oERR),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .CS    (CS)
    );

    always #5 iCLK = ~iCLK;

    // Link monitors and responder model
    int          total_rises = 0;
    int          base_rises  = 0;
    int          cs_falls    = 0;
    int          stray       = 0;
    int          done_cnt    = 0;
    int          err_cnt     = 0;
    int          miso_r;
    logic [63:0] mosi_cap    = '0;
    logic [27:0] resp_data   = 28'h5A5A5A5;
    time         t_cs_rise   = 0;
    time         last_gap    = 0;

    always @(posedge CS) t_cs_rise = $time;

    always @(negedge CS) begin
        last_gap   = $time - t_cs_rise;
        base_rises = total_rises;
        cs_falls   = cs_falls + 1;
    end

    always @(posedge SCLK) begin
        total_rises = total_rises + 1;
        mosi_cap    = {mosi_cap[62:0], MOSI};
        if (CS) stray = stray + 1;
    end

    // Responder: data bit for the next rise is presented after each fall.
    // Rises 0..6 cmd/addr, 7 turnaround, 8..35 data.
    always @(negedge SCLK) begin
        miso_r = total_rises - base_rises;
        if (miso_r >= 8 && miso_r < 36) MISO = resp_data[35 - miso_r];
        else                            MISO = 1'b0;
    end

    always @(negedge iCLK) begin
        if (oDONE) done_cnt = done_cnt + 1;
        if (oERR)  err_cnt  = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lowbits(input logic [63:0] v, input int n);
        return v & ((64'd1 << n) - 64'd1);
    endfunction

    task automatic start_req(input logic wr, input logic [5:0] addr, input logic [27:0] data);
        @(negedge iCLK);
        iSTART = 1'b1;
        iWR    = wr;
        iADDR  = addr;
        iWDATA = data;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
    endtask

    // Cycles from now (1 ns after an edge) until oDONE is seen high.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (oDONE !== 1'b1 && cyc < 400) begin
            @(posedge iCLK);
            #1;
            cyc = cyc + 1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (oBUSY !== 1'b0 && n < 100) begin
            @(posedge iCLK);
            #1;
            n = n + 1;
        end
        check("idle_reached", oBUSY, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c0, r0, e0, d0, n;

        // Asynchronous reset, checked before any clock edge
        #2 iRSTn = 1'b0;
        #1;
        check("rst_cs",    CS,     1'b1);
        check("rst_sclk",  SCLK,   1'b0);
        check("rst_mosi",  MOSI,   1'b0);
        check("rst_busy",  oBUSY,  1'b0);
        check("rst_done",  oDONE,  1'b0);
        check("rst_err",   oERR,   1'b0);
        check("rst_rdata", oRDATA, 28'h0);
        repeat (3) @(negedge iCLK);
        iRSTn = 1'b1;
        repeat (2) @(posedge iCLK);

        // Write addr 5
        r0 = total_rises;
        start_req(1'b1, 6'd5, 28'h0ABCDEF);
        check("wr1_busy", oBUSY, 1'b1);
        wait_done(lat);
        check("wr1_lat",   lat, 145);
        check("wr1_rises", total_rises - r0, 35);
        check("wr1_mosi",  lowbits(mosi_cap, 35), {29'd0, 1'b1, 6'd5, 28'h0ABCDEF});
        check("wr1_cs_hi", CS, 1'b1);
        check("wr1_rdata", oRDATA, 28'h0);
        @(posedge iCLK); #1;
        check("wr1_pulse", oDONE, 1'b0);
        wait_idle();

        // Read the last valid address
        r0 = total_rises;
        start_req(1'b0, 6'd47, 28'h0);
        wait_done(lat);
        check("rd1_lat",   lat, 149);
        check("rd1_rises", total_rises - r0, 36);
        check("rd1_mosi",  lowbits(mosi_cap, 36), 64'd47 << 29);
        check("rd1_rdata", oRDATA, 28'h5A5A5A5);
        wait_idle();

        // Out-of-range addresses are rejected
        r0 = total_rises; c0 = cs_falls; e0 = err_cnt;
        start_req(1'b0, 6'd48, 28'h0);
        check("err48_pulse", oERR,  1'b1);
        check("err48_busy",  oBUSY, 1'b0);
        check("err48_cs",    CS,    1'b1);
        @(posedge iCLK); #1;
        check("err48_once",  oERR,  1'b0);
        start_req(1'b1, 6'd63, 28'h1);
        check("err63_pulse", oERR,  1'b1);
        repeat (10) @(posedge iCLK);
        #1;
        check("err_count",   err_cnt - e0, 2);
        check("err_rises",   total_rises - r0, 0);
        check("err_csfalls", cs_falls - c0, 0);
        check("err_rdata",   oRDATA, 28'h5A5A5A5);

        // Second request 10 cycles into a write is ignored
        c0 = cs_falls;
        start_req(1'b1, 6'd33, 28'h1234567);
        repeat (9) @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b1; iWR = 1'b1; iADDR = 6'd1; iWDATA = 28'hFFFFFFF;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        wait_done(lat);
        check("ign_done",   oDONE, 1'b1);
        check("ign_frames", cs_falls - c0, 1);
        check("ign_mosi",   lowbits(mosi_cap, 35), {29'd0, 1'b1, 6'd33, 28'h1234567});
        // Request held during the gap; next CS fall must respect CS_GAP
        iSTART = 1'b1; iWR = 1'b1; iADDR = 6'd10; iWDATA = 28'h0000001;
        check("gap_busy", oBUSY, 1'b1);
        n = 0;
        while (CS !== 1'b0 && n < 50) begin
            @(posedge iCLK); #1;
            n = n + 1;
        end
        iSTART = 1'b0;
        check("gap_len", (last_gap >= CS_GAP * 10) ? 1'b1 : 1'b0, 1'b1);
        wait_done(lat);
        check("gap_done", oDONE, 1'b1);
        check("gap_mosi", lowbits(mosi_cap, 35), {29'd0, 1'b1, 6'd10, 28'h0000001});
        wait_idle();

        // iCLR aborts an in-flight read and keeps oRDATA
        d0 = done_cnt;
        start_req(1'b0, 6'd9, 28'h0);
        repeat (60) @(posedge iCLK);
        @(negedge iCLK); iCLR = 1'b1;
        @(posedge iCLK); #1;
        check("clr_cs",    CS,     1'b1);
        check("clr_sclk",  SCLK,   1'b0);
        check("clr_busy",  oBUSY,  1'b0);
        check("clr_rdata", oRDATA, 28'h5A5A5A5);
        @(negedge iCLR == 1'b1 ? iCLK : iCLK); iCLR = 1'b0;
        repeat (160) @(posedge iCLK);
        #1;
        check("clr_nodone", done_cnt - d0, 0);

        // Asynchronous reset in the middle of the data phase
        d0 = done_cnt;
        start_req(1'b1, 6'd3, 28'hFFFFFFF);
        repeat (80) @(posedge iCLK);
        n = 0;
        while (SCLK !== 1'b1 && n < 10) begin
            @(posedge iCLK); #1;
            n = n + 1;
        end
        check("mid_sclk_hi", SCLK, 1'b1);
        #2 iRSTn = 1'b0;
        #1;
        check("arst_cs",   CS,    1'b1);
        check("arst_sclk", SCLK,  1'b0);
        check("arst_busy", oBUSY, 1'b0);
        repeat (2) @(negedge iCLK);
        iRSTn = 1'b1;
        repeat (160) @(posedge iCLK);
        #1;
        check("arst_nodone", done_cnt - d0, 0);
        start_req(1'b1, 6'd47, 28'h8000001);
        wait_done(lat);
        check("arst_wr_lat",  lat, 145);
        check("arst_wr_mosi", lowbits(mosi_cap, 35), {29'd0, 1'b1, 6'd47, 28'h8000001});
        check("arst_rdata",   oRDATA, 28'h0);
        wait_idle();

        // iCLR together with iSTART in idle drops the request
        c0 = cs_falls; d0 = done_cnt;
        @(negedge iCLK);
        iCLR = 1'b1; iSTART = 1'b1; iWR = 1'b1; iADDR = 6'd2; iWDATA = 28'h0000055;
        @(posedge iCLK); #1;
        check("clrst_busy", oBUSY, 1'b0);
        check("clrst_cs",   CS,    1'b1);
        check("clrst_done", oDONE, 1'b0);
        @(negedge iCLK);
        iCLR = 1'b0; iSTART = 1'b0;
        repeat (10) @(posedge iCLK);
        #1;
        check("clrst_frames", cs_falls - c0, 0);
        check("clrst_busy2",  oBUSY, 1'b0);
        check("clrst_nodone", done_cnt - d0, 0);

        check("no_stray_sclk", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
